// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divided-clock scheduler.
// The DIV_SCHED_FIXED_PRIO_EN macro selects the arbitration policy in div_sched_arb.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // A programmed half-period of 0 is promoted to this value.
  localparam int HP_MIN = 1;

endpackage

// File: rtl/div_sched_if.sv
// Requester-side bundle of the divided-clock scheduler, plus the FSM debug view.
// Handshake: req is a level held for the whole usage period; grant is one-hot and
// changes only at a hand-over, and ack pulses for one cycle with every new grant.
interface div_sched_if #(
  parameter int NREQ = 4,
  parameter int CW   = 8
);
  import div_sched_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] half_period;
  logic [NREQ-1:0]    grant;
  logic               ack;
  logic               clk_div;
  logic               tick;
  logic               busy;
  state_e             state_dbg;

  modport master (
    output req, half_period,
    input  grant, ack, clk_div, tick, busy, state_dbg
  );

  modport slave (
    input  req, half_period,
    output grant, ack, clk_div, tick, busy, state_dbg
  );

endinterface

// File: rtl/div_sched_arb.sv
// Request vector + round-robin pointer -> one-hot winner, its index and a valid flag.
// With DIV_SCHED_FIXED_PRIO_EN defined the lowest index wins and the pointer is ignored.
module div_sched_arb #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx,
  output logic            valid
);

`ifdef DIV_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win     = '0;
        win[i]  = 1'b1;
        win_idx = PW'(i);
        valid   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    // Scan starting at the pointer so the last owner is considered last.
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        win_idx  = PW'(idx);
        valid    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/div_sched.sv
// Shared programmable clock divider: arbitrates ownership, generates clk_div/tick and
// hands over only where no short high pulse can occur. Policy macro: DIV_SCHED_FIXED_PRIO_EN.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  div_sched_if.slave  bus
);

  localparam int PW = $clog2(NREQ);

  logic [1:0]      state;
  logic [NREQ-1:0] grant_q;
  logic            ack_q;
  logic            clk_div_q;
  logic            tick_q;
  logic [CW-1:0]   count;
  logic [CW-1:0]   hp;
  logic [PW-1:0]   ptr;

  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;
  logic            win_valid;
  logic [CW-1:0]   win_hp;
  logic            owner_req;
  logic            wrap;
  logic            handover;

  div_sched_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req     (bus.req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .valid   (win_valid)
  );

  assign win_hp    = bus.half_period[win_idx*CW +: CW];
  assign owner_req = |(bus.req & grant_q);
  assign wrap      = (count == hp - CW'(1));

  // Hand-over points: from idle, an owner leaving during a low phase, or the
  // falling edge that closes a high phase (drain, or a drop sampled on that edge).
  always_comb begin
    handover = 1'b0;
    case (state)
      ST_IDLE:  handover = |bus.req;
      ST_RUN:   handover = !owner_req && (!clk_div_q || wrap);
      ST_DRAIN: handover = wrap;
      default:  handover = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      ack_q     <= 1'b0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
      count     <= '0;
      hp        <= CW'(HP_MIN);
      ptr       <= '0;
    end else begin
      ack_q  <= 1'b0;
      tick_q <= 1'b0;
      if (handover) begin
        count     <= '0;
        clk_div_q <= 1'b0;
        if (win_valid) begin
          state   <= ST_RUN;
          grant_q <= win;
          ack_q   <= 1'b1;
          hp      <= (win_hp == '0) ? CW'(HP_MIN) : win_hp;
`ifndef DIV_SCHED_FIXED_PRIO_EN
          ptr     <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
`endif
        end else begin
          state   <= ST_IDLE;
          grant_q <= '0;
        end
      end else if (state != ST_IDLE) begin
        // Only reachable with clk_div high and the phase unfinished: finish it first.
        if (state == ST_RUN && !owner_req)
          state <= ST_DRAIN;
        if (wrap) begin
          count     <= '0;
          clk_div_q <= ~clk_div_q;
          tick_q    <= ~clk_div_q;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.clk_div   = clk_div_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.state_dbg = state_e'(state);

endmodule

// File: tb/tb_div_sched.sv
// Randomized and directed bench for div_sched against a phase-arithmetic reference model.
// Honors DIV_SCHED_FIXED_PRIO_EN for the expected arbitration policy.
module tb_div_sched;
  import div_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_sched_if #(.NREQ(NREQ), .CW(CW)) bus ();

  div_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [NREQ-1:0] exp_q[$];
  logic [NREQ-1:0] seen_q[$];
  bit capture = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ownership is tracked as (owner, grant cycle, half-period); clk_div and tick are
  // then pure functions of the cycles elapsed since the grant.
  int cyc     = 0;
  int m_owner = -1;
  int m_g     = 0;
  int m_hp    = 1;
  int m_ptr   = 0;
  bit m_drain = 1'b0;
  bit m_ack   = 1'b0;

  function automatic int hp_of(input int i);
    int v;
    v = int'(bus.half_period[i*CW +: CW]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_drain = 1'b0;
    m_ack   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_arb();
    int w;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
`ifdef DIV_SCHED_FIXED_PRIO_EN
      if (w < 0 && bus.req[i]) w = i;
`else
      if (w < 0 && bus.req[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
`endif
    end
    m_drain = 1'b0;
    if (w < 0) begin
      m_owner = -1;
    end else begin
      m_owner = w;
      m_g     = cyc;
      m_hp    = hp_of(w);
      m_ack   = 1'b1;
      m_ptr   = (w + 1) % NREQ;
      exp_q.push_back(NREQ'(1) << w);
    end
  endtask

  task automatic model_step();
    int p;
    bit fall, cur;
    m_ack = 1'b0;
    if (m_owner < 0) begin
      if (|bus.req) model_arb();
    end else begin
      p    = cyc - m_g;
      fall = (p % (2 * m_hp)) == 0;
      cur  = (((p - 1) / m_hp) % 2) == 1;
      if (m_drain) begin
        if (fall) model_arb();
      end else if (!bus.req[m_owner]) begin
        if (!cur || fall) model_arb();
        else m_drain = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int p;
    logic [31:0] e_grant, e_div, e_tick;
    p       = cyc - m_g;
    e_grant = (m_owner < 0) ? 0 : (32'd1 << m_owner);
    e_div   = (m_owner < 0) ? 0 : 32'((p / m_hp) % 2);
    e_tick  = (m_owner >= 0 && (p % (2 * m_hp)) == m_hp) ? 1 : 0;
    check("grant",   32'(bus.grant),   e_grant);
    check("ack",     32'(bus.ack),     32'(m_ack));
    check("clk_div", 32'(bus.clk_div), e_div);
    check("tick",    32'(bus.tick),    e_tick);
    check("busy",    32'(bus.busy),    (m_owner >= 0) ? 1 : 0);
    if (bus.ack === 1'b1) begin
      if (exp_q.size() == 0) check("ack_unexpected", 32'(bus.ack), 0);
      else check("grant_order", 32'(bus.grant), 32'(exp_q.pop_front()));
      if (capture) seen_q.push_back(bus.grant);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advances n cycles; inputs are changed by callers only at the falling edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      if (rst_n) model_step();
      else model_reset();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic set_hp(input int i, input int v);
    bus.half_period[i*CW +: CW] = CW'(v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int o;
    logic [NREQ-1:0] order_exp[5];
    bus.req         = '1;
    bus.half_period = '0;

    // Reset held with every requester asking.
    rst_n = 1'b0;
    run(5);
    bus.req = '0;
    rst_n   = 1'b1;
    run(2);

    // Single requester reproducing the fixed divide-by-64.
    set_hp(0, 32);
    bus.req = 4'b0001;
    run(141);
    bus.req = '0;
    run(70);

    // Hand-over from a drained high phase to a slower requester.
    pulse_reset();
    set_hp(1, 3);
    set_hp(2, 5);
    bus.req = 4'b0110;
    run(5);
    bus.req = 4'b0100;
    run(2);
    run(1);
    check("drain_handover", 32'(bus.grant), 32'(4'b0100));
    run(6);
    bus.req = '0;
    run(12);

    // Zero half-period behaves as one.
    set_hp(3, 0);
    bus.req = 4'b1000;
    run(10);
    bus.req = '0;
    run(4);

    // All requesting; each owner leaves in a high phase and re-asserts while draining.
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_hp(i, 2);
    bus.req = 4'b1111;
    seen_q.delete();
    capture = 1'b1;
    run(1);
    repeat (4) begin
      run(6);
      o = (m_owner < 0) ? 0 : m_owner;
      bus.req[o] = 1'b0;
      run(1);
      bus.req[o] = 1'b1;
      run(1);
    end
    capture = 1'b0;
`ifdef DIV_SCHED_FIXED_PRIO_EN
    order_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    order_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    check("order_len", seen_q.size(), 5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++)
      check($sformatf("order_%0d", i), 32'(seen_q[i]), 32'(order_exp[i]));
    bus.req = '0;
    run(10);

    // Asynchronous reset while draining; the pointer must restart at 0.
    pulse_reset();
    set_hp(2, 4);
    bus.req = 4'b0100;
    run(5);
    bus.req = 4'b0000;
    run(1);
    bus.req = 4'b1010;
    pulse_reset();
    run(1);
    check("post_reset_grant", 32'(bus.grant), 32'(4'b0010));
    run(10);

    // Random traffic with mid-grant half-period changes and one reset.
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        o = $urandom_range(0, NREQ - 1);
        bus.req[o] = ~bus.req[o];
      end
      if ($urandom_range(0, 4) == 0)
        set_hp($urandom_range(0, NREQ - 1), $urandom_range(0, 6));
      if (k == 250) pulse_reset();
      run(1);
    end
    bus.req = '0;
    run(20);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_sched.md
# div_sched

Glitch-free divided-clock scheduler: shares one programmable clock divider among NREQ requesters, each asking for its own half-period. Arbitrates ownership with a req/grant handshake, latches the owner's ratio, generates `clk_div` plus a rising-edge tick, and switches owners only at points that never produce a short high pulse. Sits between the peripheral blocks that need slow clocks/strobes and the fixed divide-by-64 divider it generalises (half-period 32 reproduces it).

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `CW`, 8, half-period count width
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  NREQ  level request per requester; held for the whole usage period
- `half_period`  in  NREQ*CW  requester i's half-period in clk cycles at bits [i*CW +: CW]; 0 treated as 1
- `grant`  out  NREQ  one-hot current owner, 0 when idle
- `ack`  out  1  one-cycle pulse coincident with any new grant
- `clk_div`  out  1  divided clock, registered
- `tick`  out  1  one-cycle pulse on the cycle `clk_div` goes 0->1
- `busy`  out  1  high in RUN or DRAIN

## Operation
- States: IDLE, RUN, DRAIN.
- Reset values: state IDLE, `grant`=0, `ack`=0, `clk_div`=0, `tick`=0, `busy`=0, count=0, latched hp=1, RR pointer=0.
- IDLE: `clk_div` held 0. Any `req` bit high -> arbitrate, go RUN.
- Arbitrate: pick winner by round-robin starting at pointer; set `grant`, pulse `ack`, latch winner's half-period (0->1), count=0, `clk_div`=0; pointer = winner+1 mod NREQ.
- RUN counter: if count==hp-1, count<=0 and `clk_div` toggles, else count+1. High and low phases are each exactly hp cycles; period 2*hp.
- `half_period` changes while granted are ignored until the next grant.
- Owner drops `req` in RUN:
  - `clk_div`==0: arbitrate on the same edge (low phase truncated, new low phase of full new hp follows; no glitch). No other requester -> IDLE.
  - `clk_div`==1: go DRAIN; keep counting; on the edge where `clk_div` falls, arbitrate (or IDLE). High pulse always full length.
- Owner re-asserting `req` during DRAIN competes normally; pointer already past it, so others win first.
- Non-requesting bits never receive grant; grant never changes except at the points above.

## Timing
- Grant latency: `req` high sampled at edge k in IDLE -> `grant`/`ack` visible after edge k.
- First `clk_div` rise (and `tick`) at edge k+hp; falls at k+2*hp.
- `tick` and `clk_div` rising are registered on the same edge.
- Hand-over in DRAIN: new `grant`, `ack`, count=0, `clk_div`=0 all on the falling edge of the old owner's final high phase.
- Async reset mid-operation: all outputs to reset values immediately, no drain.

## Configuration
- `DIV_SCHED_FIXED_PRIO_EN` defined: fixed priority, lowest index wins, pointer unused.
- Not defined: round-robin as above.

## Structure
- Package `div_sched_pkg`: state enum (IDLE, RUN, DRAIN), `HP_MIN`=1 constant.
- One sub-module `div_sched_arb`: request vector + pointer -> one-hot winner and valid; contains the macro-selected priority logic.

## Test plan
- Reset: hold `rst_n` low 5 cycles with `req`=4'b1111 -> `grant`=0, `ack`=0, `clk_div`=0, `tick`=0, `busy`=0.
- `req[0]`, hp=32 from IDLE -> `ack` 1 cycle, `grant`=4'b0001, `clk_div` period 64, first `tick` 32 cycles after grant.
- `req[1]` hp=3 and `req[2]` hp=5 together from reset -> grant 4'b0010; drop `req[1]` one cycle into a high phase -> `clk_div` stays high 2 more cycles, then falls with `grant`=4'b0100, next rise 5 cycles later.
- `req[3]` hp=0 -> `clk_div` toggles every cycle (period 2), `tick` every other cycle.
- All four requesting, each owner drops after one full period -> grant order 0,1,2,3,0; with `DIV_SCHED_FIXED_PRIO_EN` -> 0,0,0 while `req[0]` re-asserts.
- `rst_n` pulsed low during DRAIN high phase -> `clk_div` 0 immediately, after release `req[1]` wins (pointer reset).
